host_link: RTL and testbench

Host-side link layer for the logic analyzer. It sits between the byte-level UART (receiver and transmitter) and the digital core. It assembles two received bytes into a 16-bit command with a `cmd_rdy`/`clr_cmd_rdy` handshake, and forwards each 8-bit response from the core to the UART transmitter, reporting completion with `resp_sent`. A gap timeout between the two command bytes discards partial commands, so the link resynchronizes after a lost byte.

---
 rtl/host_link.sv | 110 +++++++++++
 tb/tb_host_link.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/host_link.sv
// Host link layer: packs two UART bytes into a 16-bit command and forwards core responses to the UART TX.
// Latency: cmd valid 1 cycle after the low byte, trmt 1 cycle after send_resp; RX stalls while cmd_rdy is held, and send_resp is dropped while TX is busy.
module host_link #(
   parameter int TIMEOUT = 10000,
   parameter int TW      = 14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_rdy,
   input  logic [7:0]  rx_data,
   output logic        clr_rx_rdy,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic [7:0]  tx_data,
   output logic        trmt,
   input  logic        tx_done
);
   typedef enum logic {RX_HI, RX_LO} rx_state_t;
   typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   rx_state_t     rx_state, rx_next;
   tx_state_t     tx_state, tx_next;
   logic [TW-1:0] timer;
   logic [7:0]    hi_byte;
   logic          take_hi, take_lo;
   logic          trmt_next, sent_next;

   always_comb begin
      rx_next = rx_state;
      take_hi = 1'b0;
      take_lo = 1'b0;
      case (rx_state)
         RX_HI: if (rx_rdy && !cmd_rdy) begin
            take_hi = 1'b1;
            rx_next = RX_LO;
         end
         RX_LO: if (rx_rdy) begin
            take_lo = 1'b1;
            rx_next = RX_HI;
         end else if (timer == LAST) begin
            rx_next = RX_HI;
         end
         default: rx_next = RX_HI;
      endcase
   end

   assign clr_rx_rdy = !rst && (take_hi || take_lo);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state <= RX_HI;
         timer    <= '0;
         hi_byte  <= '0;
         cmd      <= '0;
         cmd_rdy  <= 1'b0;
      end else begin
         rx_state <= rx_next;
         if (take_hi) begin
            hi_byte <= rx_data;
            timer   <= '0;
         end else if (rx_state == RX_LO && rx_next == RX_LO) begin
            timer <= timer + 1'b1;
         end
         // Set only happens with cmd_rdy low, so set and clear never collide.
         if (take_lo) begin
            cmd     <= {hi_byte, rx_data};
            cmd_rdy <= 1'b1;
         end else if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
         end
      end
   end

   always_comb begin
      tx_next   = tx_state;
      trmt_next = 1'b0;
      sent_next = 1'b0;
      case (tx_state)
         TX_IDLE: if (send_resp) begin
            tx_next   = TX_BUSY;
            trmt_next = 1'b1;
         end
         TX_BUSY: if (tx_done) begin
            tx_next   = TX_IDLE;
            sent_next = 1'b1;
         end
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state  <= TX_IDLE;
         trmt      <= 1'b0;
         resp_sent <= 1'b0;
         tx_data   <= '0;
      end else begin
         tx_state  <= tx_next;
         trmt      <= trmt_next;
         resp_sent <= sent_next;
         if (trmt_next) tx_data <= resp;
      end
   end
endmodule

// File: tb/tb_host_link.sv
// Self-checking bench for host_link: directed scenarios then random traffic against an event-level model.
module tb_host_link;
   localparam int TO = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_rdy = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        clr_rx_rdy;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp = '0;
   logic        send_resp = 1'b0;
   logic        resp_sent;
   logic [7:0]  tx_data;
   logic        trmt;
   logic        tx_done = 1'b0;

   int checks = 0;
   int errors = 0;
   int n_clr  = 0;
   int cyc    = 0;

   // Model: a pending high byte is alive for TO edges after the edge that took it.
   logic        m_pend = 1'b0;
   logic [7:0]  m_hi = '0;
   int          m_hcyc = 0;
   logic [15:0] m_cmd = '0;
   logic        m_cmd_rdy = 1'b0;
   logic        m_busy = 1'b0;
   logic [7:0]  m_txd = '0;
   logic        m_trmt = 1'b0;
   logic        m_sent = 1'b0;

   host_link #(.TIMEOUT(TO), .TW(5)) dut (
      .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
      .resp_sent(resp_sent), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      logic alive, exp_clr, seen, cr;
      #1;
      alive   = m_pend && (cyc - m_hcyc <= TO);
      cr      = m_cmd_rdy;
      exp_clr = !rst && rx_rdy && (alive || !cr);
      check("clr_rx_rdy", {15'd0, clr_rx_rdy}, {15'd0, exp_clr});
      seen = clr_rx_rdy;
      if (seen) n_clr++;
      if (rst) begin
         m_pend = 0; m_hi = 0; m_cmd = 0; m_cmd_rdy = 0;
         m_busy = 0; m_txd = 0; m_trmt = 0; m_sent = 0;
      end else begin
         if (cr && clr_cmd_rdy) m_cmd_rdy = 0;
         if (rx_rdy && alive) begin
            m_cmd = {m_hi, rx_data}; m_cmd_rdy = 1; m_pend = 0;
         end else if (rx_rdy && !cr) begin
            m_pend = 1; m_hi = rx_data; m_hcyc = cyc;
         end else if (!alive) begin
            m_pend = 0;
         end
         m_trmt = 0; m_sent = 0;
         if (!m_busy && send_resp) begin
            m_busy = 1; m_trmt = 1; m_txd = resp;
         end else if (m_busy && tx_done) begin
            m_busy = 0; m_sent = 1;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      check("cmd", cmd, m_cmd);
      check("cmd_rdy", {15'd0, cmd_rdy}, {15'd0, m_cmd_rdy});
      check("tx_data", {8'd0, tx_data}, {8'd0, m_txd});
      check("trmt", {15'd0, trmt}, {15'd0, m_trmt});
      check("resp_sent", {15'd0, resp_sent}, {15'd0, m_sent});
      send_resp = 0; tx_done = 0; clr_cmd_rdy = 0;
      if (seen) rx_rdy = 0;
   endtask

   task automatic put_byte(input logic [7:0] b);
      rx_rdy = 1; rx_data = b;
      tick();
   endtask

   initial begin
      int c0, gap;
      // Reset state
      tick(); tick();
      rst = 0;
      check("reset cmd", cmd, 16'h0000);
      check("reset tx_data", {8'd0, tx_data}, 16'h0000);

      // Basic assembly with a 3-cycle gap
      c0 = n_clr;
      put_byte(8'h0A); tick(); tick();
      put_byte(8'h5C);
      check("cmd 0A5C", cmd, 16'h0A5C);
      check("two clr pulses", 16'(n_clr - c0), 16'd2);

      // Backpressure while cmd_rdy held
      rx_rdy = 1; rx_data = 8'h11;
      tick(); tick(); tick();
      check("held cmd", cmd, 16'h0A5C);
      clr_cmd_rdy = 1; tick();
      tick();
      put_byte(8'h22);
      check("cmd 1122", cmd, 16'h1122);
      clr_cmd_rdy = 1; tick();

      // Timeout discards partial, then fresh command
      put_byte(8'hFF);
      for (int i = 0; i < TO; i++) tick();
      put_byte(8'h01); put_byte(8'h02);
      check("cmd 0102", cmd, 16'h0102);
      clr_cmd_rdy = 1; tick();

      // Low byte exactly at expiry edge completes
      put_byte(8'hAB);
      for (int i = 0; i < TO - 1; i++) tick();
      put_byte(8'hCD);
      check("cmd ABCD expiry", cmd, 16'hABCD);
      clr_cmd_rdy = 1; tick();

      // Transmit path
      resp = 8'hA5; send_resp = 1; tick();
      check("trmt A5", {15'd0, trmt}, 16'd1);
      check("tx_data A5", {8'd0, tx_data}, 16'h00A5);
      tick();
      resp = 8'h33; send_resp = 1; tick();
      check("busy ignore", {8'd0, tx_data}, 16'h00A5);
      tx_done = 1; tick();
      check("resp_sent", {15'd0, resp_sent}, 16'd1);
      resp = 8'h33; send_resp = 1; tick();
      check("tx_data 33", {8'd0, tx_data}, 16'h0033);

      // Concurrent RX completion and TX done
      put_byte(8'h44);
      rx_rdy = 1; rx_data = 8'h55; tx_done = 1; tick();
      check("both asserted", {14'd0, cmd_rdy, resp_sent}, 16'd3);
      check("cmd 4455", cmd, 16'h4455);
      clr_cmd_rdy = 1; tick();

      // Reset mid-command and mid-transmit
      put_byte(8'h66);
      resp = 8'h77; send_resp = 1; tick();
      rst = 1; tick(); rst = 0;
      check("rst cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
      tx_done = 1; tick();
      check("no resp_sent", {15'd0, resp_sent}, 16'd0);
      put_byte(8'h77); put_byte(8'h88);
      check("cmd 7788", cmd, 16'h7788);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         gap = ((i % 1000) < 500) ? 4 : 40;
         if (!rx_rdy && $urandom_range(0, gap) == 0) begin
            rx_rdy  = 1;
            rx_data = 8'($urandom);
         end
         resp        = 8'($urandom);
         send_resp   = ($urandom_range(0, 7) == 0);
         tx_done     = ($urandom_range(0, 5) == 0);
         clr_cmd_rdy = ($urandom_range(0, 3) == 0);
         rst         = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
